// File: rtl/game_pkg.sv
// game_pkg: shared types and constants for the whack-a-mole game blocks.
// Holds the scheduler state encoding, the LFSR definition and the default
// timing values shared by game_fsm, the timer and mole_scheduler.
package game_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GAP  = 2'd1,
    S_UP   = 2'd2
  } sched_state_e;

  // 16-bit Fibonacci LFSR, taps 16,15,13,4 (bits 15,14,12,3)
  localparam int                LFSR_W    = 16;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hD008;

  localparam int DEF_NUM_MOLES    = 4;
  localparam int DEF_UP_TICKS     = 8;
  localparam int DEF_GAP_TICKS    = 3;
  localparam int DEF_MIN_UP_TICKS = 3;

  // One shift of the LFSR; feedback is the XOR of the tapped bits
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] cur);
    return {cur[LFSR_W-2:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/mole_scheduler_lfsr16.sv
// lfsr16: free-running 16-bit Fibonacci LFSR used for mole selection.
// Seeded only by reset_n; a nonzero seed on a maximal-length polynomial
// keeps it out of the all-zero lock-up state.
module lfsr16
  import game_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  output logic [15:0] q
);

  logic [LFSR_W-1:0] q_q;
  logic [LFSR_W-1:0] q_d;

  // Advance one step every clock
  always_comb begin
    q_d = lfsr_step(q_q);
  end

  // Sequence register, seeded on power-on reset only
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) q_q <= LFSR_SEED;
    else          q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/mole_scheduler.sv
// mole_scheduler: alternates gap and pop-up windows during play, picks a
// pseudo-random mole each round and classifies presses as hit/wrong/miss.
// Optional feature macro: MOLE_SPEEDUP_EN -- each hit shortens the pop-up
// window by one tick, down to MIN_UP_TICKS.
//
//   state  | meaning
//   S_IDLE | not playing; moles dark, counter cleared
//   S_GAP  | dark window between rounds, GAP_TICKS ticks
//   S_UP   | one mole lit for up_len ticks, presses classified
module mole_scheduler
  import game_pkg::*;
#(
  parameter int NUM_MOLES    = DEF_NUM_MOLES,
  parameter int UP_TICKS     = DEF_UP_TICKS,
  parameter int GAP_TICKS    = DEF_GAP_TICKS,
  parameter int MIN_UP_TICKS = DEF_MIN_UP_TICKS
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         tick,
  input  logic                         game_active,
  input  logic                         sys_reset,
  input  logic [NUM_MOLES-1:0]         hit_btn,
  output logic [NUM_MOLES-1:0]         mole_en,
  output logic [$clog2(NUM_MOLES)-1:0] mole_idx,
  output logic                         hit_pulse,
  output logic                         wrong_pulse,
  output logic                         miss_pulse
);

  localparam int IDX_W   = $clog2(NUM_MOLES);
  localparam int CNT_MAX = (UP_TICKS > GAP_TICKS) ? UP_TICKS : GAP_TICKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]     GAP_LD  = CNT_W'(GAP_TICKS);
  localparam logic [CNT_W-1:0]     UP_LD   = CNT_W'(UP_TICKS);
  localparam logic [CNT_W-1:0]     UP_MIN  = CNT_W'(MIN_UP_TICKS);
  localparam logic [CNT_W-1:0]     CNT_ONE = CNT_W'(1);
  localparam logic [IDX_W-1:0]     IDX_ONE = IDX_W'(1);
  localparam logic [NUM_MOLES-1:0] HOT_ONE = NUM_MOLES'(1);

`ifdef MOLE_SPEEDUP_EN
  localparam bit SPEEDUP = 1'b1;
`else
  localparam bit SPEEDUP = 1'b0;
`endif

  sched_state_e           state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       up_len_q, up_len_d;
  logic [IDX_W-1:0]       mole_idx_q, mole_idx_d;
  logic [NUM_MOLES-1:0]   btn_prev_q, btn_prev_d;
  logic                   hit_q, hit_d;
  logic                   wrong_q, wrong_d;
  logic                   miss_q, miss_d;

  logic [LFSR_W-1:0]      lfsr_q;
  logic [NUM_MOLES-1:0]   press;
  logic [NUM_MOLES-1:0]   lit_hot;
  logic [IDX_W-1:0]       cand;
  logic [IDX_W-1:0]       next_mole;
  logic                   is_hit;
  logic                   is_wrong;
  logic                   last_tick;
  logic                   lfsr_unused;

  lfsr16 u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .q       (lfsr_q)
  );

  // Only the low index bits pick the mole
  assign lfsr_unused = ^lfsr_q[LFSR_W-1:IDX_W];

  // Press edges, current-mole decode and next-mole pick (never repeats)
  always_comb begin
    press     = hit_btn & ~btn_prev_q;
    lit_hot   = HOT_ONE << mole_idx_q;
    is_hit    = |(press & lit_hot);
    is_wrong  = |(press & ~lit_hot);
    last_tick = tick && (cnt_q == CNT_ONE);
    cand      = lfsr_q[IDX_W-1:0];
    next_mole = (cand == mole_idx_q) ? cand + IDX_ONE : cand;
  end

  // Next-state and registered-pulse logic; priority sys_reset > !game_active > hit > expiry > wrong
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    up_len_d   = up_len_q;
    mole_idx_d = mole_idx_q;
    btn_prev_d = hit_btn;
    hit_d      = 1'b0;
    wrong_d    = 1'b0;
    miss_d     = 1'b0;

    if (sys_reset) begin
      state_d    = S_IDLE;
      cnt_d      = '0;
      up_len_d   = UP_LD;
      mole_idx_d = '0;
    end else if (!game_active) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_GAP;
          cnt_d   = GAP_LD;
        end
        S_GAP: begin
          if (tick) begin
            if (cnt_q == CNT_ONE) begin
              state_d    = S_UP;
              cnt_d      = up_len_q;
              mole_idx_d = next_mole;
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end
        end
        S_UP: begin
          if (is_hit) begin
            hit_d   = 1'b1;
            state_d = S_GAP;
            cnt_d   = GAP_LD;
            if (SPEEDUP && (up_len_q > UP_MIN)) up_len_d = up_len_q - CNT_ONE;
          end else if (last_tick) begin
            miss_d  = 1'b1;
            state_d = S_GAP;
            cnt_d   = GAP_LD;
          end else begin
            wrong_d = is_wrong;
            if (tick) cnt_d = cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, counters and pulse registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      up_len_q   <= UP_LD;
      mole_idx_q <= '0;
      btn_prev_q <= '1;
      hit_q      <= 1'b0;
      wrong_q    <= 1'b0;
      miss_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      up_len_q   <= up_len_d;
      mole_idx_q <= mole_idx_d;
      btn_prev_q <= btn_prev_d;
      hit_q      <= hit_d;
      wrong_q    <= wrong_d;
      miss_q     <= miss_d;
    end
  end

  // Moore decode of the lit mole
  always_comb begin
    mole_en = (state_q == S_UP) ? lit_hot : '0;
  end

  assign mole_idx    = mole_idx_q;
  assign hit_pulse   = hit_q;
  assign wrong_pulse = wrong_q;
  assign miss_pulse  = miss_q;

endmodule

// File: tb/tb_mole_scheduler.sv
// tb_mole_scheduler: directed scenarios plus randomized play, all compared
// against a round-level behavioural model of the scheduler.
module tb_mole_scheduler;

  localparam int N     = 4;
  localparam int UP    = 8;
  localparam int GAP   = 3;
  localparam int MINUP = 3;
`ifdef MOLE_SPEEDUP_EN
  localparam bit SPD = 1'b1;
`else
  localparam bit SPD = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n;
  logic         tick;
  logic         game_active;
  logic         sys_reset;
  logic [N-1:0] hit_btn;
  logic [N-1:0] mole_en;
  logic [1:0]   mole_idx;
  logic         hit_pulse;
  logic         wrong_pulse;
  logic         miss_pulse;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  mole_scheduler #(
    .NUM_MOLES    (N),
    .UP_TICKS     (UP),
    .GAP_TICKS    (GAP),
    .MIN_UP_TICKS (MINUP)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .tick        (tick),
    .game_active (game_active),
    .sys_reset   (sys_reset),
    .hit_btn     (hit_btn),
    .mole_en     (mole_en),
    .mole_idx    (mole_idx),
    .hit_pulse   (hit_pulse),
    .wrong_pulse (wrong_pulse),
    .miss_pulse  (miss_pulse)
  );

  // Reference model: phase 0 = idle, 1 = dark gap, 2 = mole up
  int           m_phase, m_left, m_mole, m_uplen;
  logic [N-1:0] m_prev;
  logic [15:0]  m_lfsr;
  bit           m_hit, m_wrong, m_miss;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, want, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_left = 0; m_mole = 0; m_uplen = UP;
    m_prev  = '1; m_lfsr = 16'hACE1;
    m_hit = 0; m_wrong = 0; m_miss = 0;
  endtask

  task automatic model_step(input bit tk, input bit ga, input bit sr, input logic [N-1:0] btn);
    logic [N-1:0] press;
    int c;
    press  = btn & ~m_prev;
    m_prev = btn;
    m_hit = 0; m_wrong = 0; m_miss = 0;
    if (sr) begin
      m_phase = 0; m_left = 0; m_uplen = UP; m_mole = 0;
    end else if (!ga) begin
      m_phase = 0; m_left = 0;
    end else if (m_phase == 0) begin
      m_phase = 1; m_left = GAP;
    end else if (m_phase == 1) begin
      if (tk) begin
        m_left--;
        if (m_left == 0) begin
          c = int'(m_lfsr) % N;
          if (c == m_mole) c = (c + 1) % N;
          m_mole = c; m_phase = 2; m_left = m_uplen;
        end
      end
    end else begin
      if (press[m_mole]) begin
        m_hit = 1; m_phase = 1; m_left = GAP;
        if (SPD && m_uplen > MINUP) m_uplen--;
      end else if (tk && m_left == 1) begin
        m_miss = 1; m_phase = 1; m_left = GAP;
      end else begin
        m_wrong = (press != 0);
        if (tk) m_left--;
      end
    end
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[14] ^ m_lfsr[12] ^ m_lfsr[3]};
  endtask

  // One clock: drive at the falling edge, model the rising edge, compare at the next falling edge
  task automatic step(input bit tk, input bit ga, input bit sr, input logic [N-1:0] btn);
    tick = tk; game_active = ga; sys_reset = sr; hit_btn = btn;
    model_step(tk, ga, sr, btn);
    @(negedge clk);
    cyc++;
    chk("mole_en", mole_en, (m_phase == 2) ? (N'(1) << m_mole) : '0);
    chk("mole_idx", mole_idx, m_mole);
    chk("hit_pulse", hit_pulse, m_hit);
    chk("wrong_pulse", wrong_pulse, m_wrong);
    chk("miss_pulse", miss_pulse, m_miss);
  endtask

  task automatic wait_lit();
    int n;
    n = 0;
    while (mole_en == '0 && n < 200) begin
      step(cyc % 2, 1, 0, '0);
      n++;
    end
    chk("wait_lit_in_time", (mole_en != '0), 1);
  endtask

  // Let one window expire and return its length in ticks
  task automatic measure_window(input int prev, output int w);
    bit up_before, tk, done;
    wait_lit();
    if (prev >= 0) chk("new_mole_differs", (int'(mole_idx) != prev), 1);
    w = 0; done = 0;
    for (int n = 0; n < 200 && !done; n++) begin
      up_before = (mole_en != '0);
      tk = cyc % 2;
      step(tk, 1, 0, '0);
      if (up_before && tk) w++;
      if (miss_pulse) done = 1;
    end
    chk("window_expired_in_time", done, 1);
  endtask

  // Wrong press, release, then correct press; returns the struck index
  task automatic hit_round(output int k);
    wait_lit();
    k = int'(mole_idx);
    step(0, 1, 0, N'(1) << ((k + 1) % N));
    chk("wrong_seen", wrong_pulse, 1);
    chk("lit_after_wrong", mole_en, N'(1) << k);
    step(0, 1, 0, '0);
    step(0, 1, 0, N'(1) << k);
    chk("hit_seen", hit_pulse, 1);
    chk("dark_on_hit", mole_en, '0);
    step(0, 1, 0, '0);
    chk("hit_one_cycle", hit_pulse, 0);
  endtask

  function automatic int exp_win(input int hits);
    int w;
    w = UP - hits;
    if (w < MINUP) w = MINUP;
    return SPD ? w : UP;
  endfunction

  initial begin
    int tk_cnt, lit_ticks, w, k;
    bit lit_seen, done, up_before, tk, ga, sr;
    logic [N-1:0] b;

    reset_n = 1'b0; tick = 1'b0; game_active = 1'b0; sys_reset = 1'b0; hit_btn = '1;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_mole_en", mole_en, 0);
    chk("rst_mole_idx", mole_idx, 0);
    chk("rst_pulses", {hit_pulse, wrong_pulse, miss_pulse}, 0);
    reset_n = 1'b1;

    // Arming with buttons held from reset: 3 ticks dark, 8 ticks lit, then a miss
    tk_cnt = 0; lit_ticks = 0; lit_seen = 0; done = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      tk = (c % 4 == 3);
      up_before = (mole_en != '0);
      step(tk, 1, 0, '1);
      if (tk) tk_cnt++;
      chk("arm_no_hit_wrong", {hit_pulse, wrong_pulse}, 0);
      if (!lit_seen) begin
        chk("arm_no_early_miss", miss_pulse, 0);
        if (mole_en != '0) begin
          lit_seen = 1;
          chk("arm_gap_ticks", tk_cnt, GAP);
        end
      end else begin
        if (up_before && tk) lit_ticks++;
        if (mole_en != '0) chk("arm_onehot", $onehot(mole_en), 1);
        if (miss_pulse) begin
          chk("arm_up_ticks", lit_ticks, UP);
          done = 1;
        end
      end
    end
    chk("arm_in_time", done, 1);
    step(0, 1, 0, '1);
    chk("miss_one_cycle", miss_pulse, 0);

    // Window lengths across consecutive hits (shrinking only with speedup)
    step(0, 1, 1, '0);
    k = -1;
    for (int h = 0; h <= 6; h++) begin
      measure_window(k, w);
      chk("window_len", w, exp_win(h));
      if (h < 6) hit_round(k);
    end

    // Press edge on the final tick counts as a hit only
    step(0, 1, 1, '0);
    wait_lit();
    k = int'(mole_idx);
    for (int n = 0; n < UP - 1; n++) step(1, 1, 0, '0);
    step(1, 1, 0, N'(1) << k);
    chk("final_tick_hit", hit_pulse, 1);
    chk("final_tick_no_miss", miss_pulse, 0);
    step(0, 1, 0, '0);
    chk("final_tick_no_late_miss", miss_pulse, 0);

    // Abort mid-window, then sys_reset restores the full window
    hit_round(k);
    wait_lit();
    step(1, 0, 0, '0);
    chk("abort_dark", mole_en, 0);
    chk("abort_no_pulse", {hit_pulse, wrong_pulse, miss_pulse}, 0);
    step(0, 1, 1, '0);
    measure_window(-1, w);
    chk("window_after_sys_reset", w, UP);

    // Randomized play
    for (int i = 0; i < 4000; i++) begin
      tk = ($urandom_range(0, 2) == 0);
      ga = ($urandom_range(0, 99) != 0);
      sr = ($urandom_range(0, 299) == 0);
      b  = hit_btn;
      case ($urandom_range(0, 7))
        0, 1:    b = N'($urandom);
        2, 3:    if (m_phase == 2) b = N'(1) << m_mole;
        4:       b = '0;
        default: b = hit_btn;
      endcase
      step(tk, ga, sr, b);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mole_scheduler.md
# mole_scheduler

Sequences the moles during play. Sits downstream of `game_fsm` and is gated by its `game_active` / `sys_reset` outputs. While play is active it alternates gap and pop-up windows, picks a pseudo-random mole per round, and classifies player presses as hit, wrong or miss. Results leave as single-cycle pulses toward the score counter and display.

## Interface
- `NUM_MOLES`, 4: number of moles/buttons; power of two, 2..8.
- `UP_TICKS`, 8: pop-up window length, in `tick` strobes; ≥2.
- `GAP_TICKS`, 3: dark window between rounds, in `tick` strobes; ≥1.
- `MIN_UP_TICKS`, 3: floor for the pop-up window (used only with `MOLE_SPEEDUP_EN`).
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `tick` in 1: timebase strobe, one `clk` wide, synchronous to `clk`.
- `game_active` in 1: from `game_fsm`; high = play.
- `sys_reset` in 1: from `game_fsm`; synchronous clear.
- `hit_btn` in NUM_MOLES: player buttons; debounced and synchronised externally; level.
- `mole_en` out NUM_MOLES: one-hot lit mole; all zero when no mole is up.
- `mole_idx` out $clog2(NUM_MOLES): index of the current/last mole.
- `hit_pulse` out 1: correct mole struck.
- `wrong_pulse` out 1: button pressed for an unlit mole.
- `miss_pulse` out 1: pop-up window expired with no hit.

## Operation
- Button press detection:
  - Registered per-bit `btn_prev`.
  - `press = hit_btn & ~btn_prev`.
- States:
  - S_IDLE: moles dark, counters cleared.
    - Goes to S_GAP when `game_active` is high.
  - S_GAP: `cnt` is loaded with GAP_TICKS and decremented on `tick`.
    - On the tick where `cnt==1`, the next mole is chosen and the state goes to S_UP with `cnt` loaded from `up_len`.
  - S_UP: `mole_en` is the one-hot of `mole_idx`. `cnt` is decremented on `tick`.
    - A press on `mole_idx` gives `hit_pulse`, then S_GAP.
    - Any other press gives `wrong_pulse` and the state stays in S_UP.
    - When `tick` arrives with `cnt==1` and there is no hit, the result is `miss_pulse`, then S_GAP.
- Mole selection:
  - A 16-bit Fibonacci LFSR (taps 16,15,13,4) steps every `clk`.
  - Its seed is 16'hACE1 on `reset_n` only.
  - The candidate is `lfsr[$clog2(NUM_MOLES)-1:0]`.
  - If the candidate equals the previous `mole_idx`, it is incremented modulo NUM_MOLES, so the same mole never appears twice in a row.
- `up_len` is a register. Its reset value is UP_TICKS.
- Simultaneous events, in priority order:
  1. `sys_reset`
  2. `game_active` low
  3. hit
  4. expiry
  5. wrong
- A hit and expiry in the same cycle count as a hit only.
- A hit plus a wrong press in the same cycle produces `hit_pulse` only.
- Presses in S_IDLE and S_GAP are ignored; they produce no pulse.
- A button held across the S_GAP→S_UP boundary does not count; a new rising edge is required.
- `game_active` low in any state: next cycle is S_IDLE, `mole_en` is zero, and no miss or hit pulse is generated.
- `sys_reset` high: synchronous return to S_IDLE, `cnt` cleared, `up_len` set to UP_TICKS, `mole_idx` set to 0. The LFSR is not reseeded.

## Timing
- Reset values (`reset_n` low):
  - state S_IDLE, `mole_en` 0, `mole_idx` 0, all pulses 0.
  - `btn_prev` all ones, so a button held through reset produces no edge.
  - `lfsr` 16'hACE1, `up_len` UP_TICKS.
- Outputs:
  - `mole_en` is Moore, decoded from registered state and `mole_idx`.
  - The pulses are registered, exactly one `clk` wide.
- Latency:
  - A press edge in cycle N gives the pulse in cycle N+1.
  - For a hit, `mole_en` drops in N+1 (state S_GAP).
- Window lengths:
  - S_UP lasts exactly `up_len` tick strobes; `mole_en` falls the cycle after the final tick.
  - S_GAP lasts exactly GAP_TICKS strobes.
  - S_IDLE→S_GAP takes one cycle after `game_active` rises.

## Configuration
- `MOLE_SPEEDUP_EN` defined:
  - Each `hit_pulse` decrements `up_len` by 1, saturating at MIN_UP_TICKS.
  - The new length applies from the next S_UP entry.
  - Misses and wrong presses do not change `up_len`.
- Undefined: `up_len` is constant UP_TICKS and the MIN_UP_TICKS parameter is unused.

## Structure
- Package `game_pkg`:
  - Scheduler state enum (S_IDLE, S_GAP, S_UP), 2 bits.
  - LFSR width, taps and seed constants.
  - Default timing constants shared with `game_fsm` and the timer.
- Sub-module `lfsr16`:
  - Ports `clk`, `reset_n`, `q[15:0]`.
  - Free-running, never reaches the zero state.
- Edge detection, counters and the FSM stay in `mole_scheduler`.

## Test plan
- Reset and arming: hold `reset_n` low with `hit_btn`=4'b1111, release, `game_active`=1, buttons stay high.
  - Required: no pulses.
  - `mole_en` is first nonzero after exactly 3 ticks.
  - It stays one-hot for exactly 8 ticks, then `miss_pulse` is high for 1 cycle.
- Hit: with mole k lit, raise `hit_btn[k]`.
  - Required: `hit_pulse` high for one cycle, the cycle after the edge; `mole_en`=0 that same cycle.
  - A second round starts 3 ticks later with an index ≠ k.
- Wrong then hit: with mole 2 lit, press button 0, then button 2.
  - Required: one `wrong_pulse`, the mole stays lit, then one `hit_pulse`.
- Simultaneous: button k edge in the same cycle as the final tick.
  - Required: `hit_pulse` only, no `miss_pulse`.
- Abort: drop `game_active` mid-S_UP.
  - Required: `mole_en`=0 next cycle, no pulses.
  - `sys_reset` then restores `up_len`=8.
- `MOLE_SPEEDUP_EN`: 6 consecutive hits with UP_TICKS=8 and MIN_UP_TICKS=3.
  - Required: windows of 8, 7, 6, 5, 4, 3, then 3 ticks.
